// File: rtl/rob_bypass_table.sv
// rob_bypass_table: speculative result table indexed by ROB tag.
// Two combinational read ports with write-through bypass, one write port,
// one invalidate (commit) port, a synchronous flush and a registered
// occupancy counter kept in step with the valid bits.
module rob_bypass_table #(
    parameter int NUM_REGISTERS     = 8,
    parameter int LOG_NUM_REGISTERS = 3,
    parameter int WIDTH             = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LOG_NUM_REGISTERS-1:0] ra,
    input  logic [LOG_NUM_REGISTERS-1:0] rb,
    output logic [WIDTH-1:0]             a,
    output logic [WIDTH-1:0]             b,
    output logic                         a_valid,
    output logic                         b_valid,
    input  logic                         writeEnable,
    input  logic [LOG_NUM_REGISTERS-1:0] writeAddr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         invEnable,
    input  logic [LOG_NUM_REGISTERS-1:0] invAddr,
    input  logic                         flush,
    output logic [LOG_NUM_REGISTERS:0]   valid_count
);

    logic [WIDTH-1:0]         data [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] valid;

    logic                         wr_act;
    logic                         inv_act;
    logic                         cnt_inc;
    logic                         cnt_dec;
    logic [LOG_NUM_REGISTERS:0]   count_next;

    // Qualified write/invalidate and the incremental occupancy update.
    // An invalidate that hits the entry being written is overridden by the
    // write, so it must not decrement the count.
    always_comb begin
        wr_act     = writeEnable && !flush;
        inv_act    = invEnable && !flush;
        cnt_inc    = wr_act && !valid[writeAddr];
        cnt_dec    = inv_act && valid[invAddr] && !(wr_act && (writeAddr == invAddr));
        count_next = valid_count;
        if (cnt_inc && !cnt_dec) begin
            count_next = valid_count + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            count_next = valid_count - 1'b1;
        end
    end

    // Data storage: flush leaves the data untouched, only validity is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                data[i] <= '0;
            end
        end else if (wr_act) begin
            data[writeAddr] <= d;
        end
    end

    // Valid bits: the write is applied after the invalidate so it wins on a
    // same-index collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (invEnable) begin
                valid[invAddr] <= 1'b0;
            end
            if (writeEnable) begin
                valid[writeAddr] <= 1'b1;
            end
        end
    end

    // Occupancy counter; saturates naturally because it tracks popcount(valid).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_count <= '0;
        end else if (flush) begin
            valid_count <= '0;
        end else begin
            valid_count <= count_next;
        end
    end

    // Read ports with write-through bypass; forced to zero while in reset so
    // the bypass path cannot leak a value during reset.
    always_comb begin
        a       = '0;
        a_valid = 1'b0;
        b       = '0;
        b_valid = 1'b0;
        if (!reset) begin
            if (wr_act && (ra == writeAddr)) begin
                a       = d;
                a_valid = 1'b1;
            end else begin
                a       = data[ra];
                a_valid = valid[ra];
            end
            if (wr_act && (rb == writeAddr)) begin
                b       = d;
                b_valid = 1'b1;
            end else begin
                b       = data[rb];
                b_valid = valid[rb];
            end
        end
    end

endmodule

// File: tb/tb_rob_bypass_table.sv
// Self-checking bench for rob_bypass_table: directed steps from the test
// plan, a randomized phase against an array-based reference model, and a
// 16x8 instance exercising full occupancy without wrap.
module tb_rob_bypass_table;

    logic       clk;
    logic       reset;
    logic [2:0] ra, rb, writeAddr, invAddr;
    logic [2:0] a, b, d;
    logic       a_valid, b_valid, writeEnable, invEnable, flush;
    logic [3:0] valid_count;

    logic [3:0] ra2, rb2, wa2, ia2;
    logic [7:0] a2, b2, d2;
    logic       av2, bv2, we2, ie2, fl2;
    logic [4:0] count2;

    int total = 0;
    int bad   = 0;

    // reference model
    int m_data  [8];
    bit m_valid [8];

    rob_bypass_table dut (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .a(a), .b(b),
        .a_valid(a_valid), .b_valid(b_valid), .writeEnable(writeEnable),
        .writeAddr(writeAddr), .d(d), .invEnable(invEnable), .invAddr(invAddr),
        .flush(flush), .valid_count(valid_count)
    );

    rob_bypass_table #(.NUM_REGISTERS(16), .LOG_NUM_REGISTERS(4), .WIDTH(8)) dut16 (
        .clk(clk), .reset(reset), .ra(ra2), .rb(rb2), .a(a2), .b(b2),
        .a_valid(av2), .b_valid(bv2), .writeEnable(we2),
        .writeAddr(wa2), .d(d2), .invEnable(ie2), .invAddr(ia2),
        .flush(fl2), .valid_count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int popcount_model();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    // expected read value given the currently applied inputs
    task automatic exp_read(input int idx, output int ed, output int ev);
        if (writeEnable && !flush && idx == int'(writeAddr)) begin
            ed = int'(d);
            ev = 1;
        end else begin
            ed = m_data[idx];
            ev = m_valid[idx] ? 1 : 0;
        end
    endtask

    task automatic check_reads(input string when);
        int ed, ev;
        exp_read(int'(ra), ed, ev);
        check({when, "_a"}, int'(a), ed);
        check({when, "_a_valid"}, int'(a_valid), ev);
        exp_read(int'(rb), ed, ev);
        check({when, "_b"}, int'(b), ed);
        check({when, "_b_valid"}, int'(b_valid), ev);
    endtask

    // one clock of stimulus: check bypass before the edge, state after it
    task automatic step(input bit we, input int wa, input int dv, input bit ie,
                        input int ia, input bit fl, input int r_a, input int r_b);
        writeEnable = we;
        writeAddr   = 3'(wa);
        d           = 3'(dv);
        invEnable   = ie;
        invAddr     = 3'(ia);
        flush       = fl;
        ra          = 3'(r_a);
        rb          = 3'(r_b);
        #1;
        check_reads("pre");
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
        end else begin
            if (ie) m_valid[ia] = 0;
            if (we) begin
                m_data[wa]  = dv;
                m_valid[wa] = 1;
            end
        end
        #1;
        check("count", int'(valid_count), popcount_model());
        check_reads("post");
    endtask

    task automatic idle_read(input int r_a, input int r_b);
        step(0, 0, 0, 0, 0, 0, r_a, r_b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = 0;
            m_valid[i] = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        writeEnable = 0; writeAddr = 0; d = 0; invEnable = 0; invAddr = 0;
        flush = 0; ra = 0; rb = 7;
        we2 = 0; wa2 = 0; d2 = 0; ie2 = 0; ia2 = 0; fl2 = 0; ra2 = 0; rb2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 0);
        check("rst_a_valid", int'(a_valid), 0);
        check("rst_b_valid", int'(b_valid), 0);
        check("rst_count", int'(valid_count), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // bypass on write with ra=3
        step(1, 3, 5, 0, 0, 0, 3, 7);
        check("wr3_count", int'(valid_count), 1);
        idle_read(3, 0);

        // fill 1..7 then entry 0
        for (int i = 1; i < 8; i++) step(1, i, i, 0, 0, 0, i, (i + 1) % 8);
        step(1, 0, 2, 0, 0, 0, 0, 4);
        check("full_count", int'(valid_count), 8);
        step(1, 4, 6, 0, 0, 0, 1, 4);
        check("rewrite_count", int'(valid_count), 8);
        check("rewrite_b", int'(b), 6);

        // write + invalidate same index, then invalidate alone
        step(0, 0, 0, 1, 2, 0, 2, 2);
        step(1, 2, 7, 1, 2, 0, 2, 2);
        check("wi_same_valid", int'(a_valid), 1);
        step(0, 0, 0, 1, 2, 0, 1, 2);
        check("inv2_bvalid", int'(b_valid), 0);
        // write and invalidate different indices
        step(1, 2, 3, 1, 5, 0, 5, 2);
        // invalidate of an invalid entry, and invalidate not bypassed
        step(0, 0, 0, 1, 5, 0, 5, 5);

        // flush with a write to 5
        step(1, 5, 4, 0, 0, 1, 5, 0);
        check("flush_count", int'(valid_count), 0);
        idle_read(5, 1);

        // async reset between edges with 3 valid entries
        step(1, 1, 1, 0, 0, 0, 1, 2);
        step(1, 2, 2, 0, 0, 0, 1, 2);
        step(1, 6, 3, 0, 0, 0, 6, 2);
        check("pre_rst_count", int'(valid_count), 3);
        writeEnable = 1; writeAddr = 3'd1; d = 3'd7; ra = 3'd1; rb = 3'd2;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_count", int'(valid_count), 0);
        check("async_a_valid", int'(a_valid), 0);
        check("async_a", int'(a), 0);
        check("async_b_valid", int'(b_valid), 0);
        model_reset();
        writeEnable = 0;
        #2;
        reset = 1'b0;
        #1;
        idle_read(1, 2);
        step(1, 4, 5, 0, 0, 0, 4, 1);

        // randomized phase
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 7), $urandom_range(0, 7));
        end

        // 16-entry, 8-bit instance: fill all entries
        writeEnable = 0; invEnable = 0; flush = 0;
        for (int i = 0; i < 16; i++) begin
            we2 = 1; wa2 = 4'(i); d2 = 8'(i * 13 + 100);
            @(posedge clk);
            #1;
        end
        we2 = 0;
        #1;
        check("p16_full_count", int'(count2), 16);
        for (int i = 0; i < 16; i++) begin
            ra2 = 4'(i); rb2 = 4'(15 - i);
            #1;
            check("p16_a", int'(a2), (i * 13 + 100) % 256);
            check("p16_b", int'(b2), ((15 - i) * 13 + 100) % 256);
            check("p16_a_valid", int'(av2), 1);
        end
        we2 = 1; wa2 = 4'd9; d2 = 8'd255;
        @(posedge clk);
        #1;
        we2 = 0;
        check("p16_rewrite_count", int'(count2), 16);
        ie2 = 1; ia2 = 4'd0;
        @(posedge clk);
        #1;
        ie2 = 0;
        check("p16_inv_count", int'(count2), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_bypass_table.md
Name: rob_bypass_table

Overview:
- Parametrised successor to the 8x3 ROB bypass register file.
- Holds speculative results indexed by ROB tag.
- Two combinational read ports, each with a per-entry valid flag and same-cycle write-through bypass.
- One write (result) port, one invalidate (commit) port, a global flush and a live occupancy counter.
- Sits between the writeback stage and operand read; readers use a_valid/b_valid to decide whether to take the bypass value or wait.

Parameters:
- NUM_REGISTERS, 8, number of entries; must be a power of 2, 2..64.
- LOG_NUM_REGISTERS, 3, log2(NUM_REGISTERS); index width.
- WIDTH, 3, data bits per entry, 1..32.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ra  in  LOG_NUM_REGISTERS  read index, port A.
- rb  in  LOG_NUM_REGISTERS  read index, port B.
- a  out  WIDTH  read data, port A.
- b  out  WIDTH  read data, port B.
- a_valid  out  1  entry ra holds a valid result.
- b_valid  out  1  entry rb holds a valid result.
- writeEnable  in  1  write d into writeAddr and set its valid bit.
- writeAddr  in  LOG_NUM_REGISTERS  write index.
- d  in  WIDTH  write data.
- invEnable  in  1  clear the valid bit of invAddr (commit/retire).
- invAddr  in  LOG_NUM_REGISTERS  invalidate index.
- flush  in  1  synchronous clear of all valid bits.
- valid_count  out  LOG_NUM_REGISTERS+1  number of valid entries.

Behaviour:
- Storage: NUM_REGISTERS x WIDTH data registers plus NUM_REGISTERS valid flops.
- Reset (async, while reset=1):
  - All data flops = 0, all valid = 0, valid_count = 0.
  - a = b = 0 and a_valid = b_valid = 0, bypass included.
- Write: at posedge with writeEnable=1 and flush=0, data[writeAddr] <= d and valid[writeAddr] <= 1.
- Invalidate: at posedge with invEnable=1 and flush=0, valid[invAddr] <= 0. Data is retained but is unreadable as valid.
- Write and invalidate to the same index in the same cycle: the write wins; the entry ends valid with the new data.
- Write and invalidate to different indices: both take effect.
- Flush: at posedge with flush=1, all valid <= 0 and valid_count <= 0. Any write or invalidate in that cycle is ignored; data registers are unchanged.
- Read (combinational, zero latency):
  - If writeEnable=1, flush=0 and ra==writeAddr: a = d and a_valid = 1 (write-through bypass).
  - Otherwise: a = data[ra] and a_valid = valid[ra].
  - a is driven by data even when a_valid=0.
  - Port B is identical using rb.
  - ra==rb is legal; both ports return the same value.
- Invalidate is not bypassed: a read of invAddr in the same cycle returns the pre-edge state.
- valid_count:
  - Registered; after every edge it equals popcount(valid).
  - Implemented incrementally:
    - +1 when a write targets an invalid entry.
    - -1 when an invalidate clears a valid entry not written that cycle.
    - Net 0 when both occur on different indices with those conditions.
  - Maximum value is NUM_REGISTERS, hence the +1 width. It never wraps.
- Writing an already-valid entry overwrites the data; the count is unchanged.
- Invalidating an already-invalid entry is a no-op.
- Reset asserted mid-operation clears everything immediately, independent of clk. The first edge after deassertion behaves normally.
- The read mux and write decode are generic over NUM_REGISTERS; no multipliers outside the ALU.

Test Plan:
- Reset, then read ra=0, rb=7 -> a=b=0, a_valid=b_valid=0, valid_count=0.
- Write d=5 to writeAddr=3 with ra=3 in the same cycle -> a=5, a_valid=1 before the edge (bypass); after the edge, a=5 from storage and valid_count=1.
- Write 1..7 to entries 1..7, then entry 0 (d=2) -> valid_count=8. Rewrite entry 4 with d=6 -> count stays 8, and rb=4 gives b=6.
- Same cycle: write index 2 (d=7) and invalidate index 2 -> entry 2 valid with 7, count +1 if it was invalid. Next cycle, invalidate 2 alone -> b_valid=0, count -1.
- Fill 4 entries, then assert flush together with writeEnable to index 5 -> after the edge, valid_count=0, all valid=0, and index 5 does not become valid.
- Assert reset between clock edges with 3 valid entries -> valid_count=0 and a_valid=0 immediately. Parameter sweep NUM_REGISTERS=16, WIDTH=8: fill all 16 -> valid_count=16, no wrap.
